// File: rtl/acc_requantize.sv
// Accumulator requantizer: round, arithmetic shift, optional ReLU, saturate.
// Two-stage pipeline feeding a small output FIFO with valid/ready handshakes.
module acc_requantize #(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   cfg_load,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic                   cfg_relu,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [15:0]            sat_count,
    output logic                   busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = IN_WIDTH + 1;
    localparam logic signed [SW-1:0] QMAX = SW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] QMIN = ~QMAX;

    logic [SHIFT_WIDTH-1:0]      shift_q;
    logic                        relu_q;
    logic                        s1_valid;
    logic                        s2_valid;
    logic signed [SW-1:0]        s1_sum;
    logic [OUT_WIDTH-1:0]        s2_data;
    logic [OUT_WIDTH-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW:0]                 count;
    logic [AW+1:0]               occ;
    logic                        accept;
    logic                        pop;
    logic                        cfg_take;
    logic [SHIFT_WIDTH-1:0]      shift_new;
    logic signed [SW-1:0]        bias;
    logic signed [SW-1:0]        sum_c;
    logic signed [SW-1:0]        q;
    logic                        sat_hi;
    logic                        sat_lo;
    logic [OUT_WIDTH-1:0]        q_out;

    // Occupancy counts in-flight items so the FIFO can never overflow.
    assign occ = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
    assign in_ready = !reset && (occ < (AW+2)'(FIFO_DEPTH));
    assign accept = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign out_data = out_valid ? mem[rd_ptr] : '0;
    assign pop = out_valid && out_ready;
    assign busy = s1_valid || s2_valid || (count != '0);
    assign cfg_take = cfg_load && !busy && !accept;

    always_comb begin
        shift_new = cfg_shift;
        if (int'(cfg_shift) >= IN_WIDTH)
            shift_new = SHIFT_WIDTH'(IN_WIDTH - 1);
    end

    always_comb begin
        bias = '0;
        if (shift_q != '0)
            bias = SW'(1) << (shift_q - 1'b1);
        sum_c = $signed({in_data[IN_WIDTH-1], in_data}) + bias;
    end

    always_comb begin
        q = s1_sum >>> shift_q;
        if (relu_q && q[SW-1])
            q = '0;
        sat_hi = (q > QMAX);
        sat_lo = (q < QMIN);
        q_out = q[OUT_WIDTH-1:0];
        if (sat_hi)
            q_out = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (sat_lo)
            q_out = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            relu_q    <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_sum    <= '0;
            s2_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sat_count <= '0;
        end else begin
            if (cfg_take) begin
                shift_q <= shift_new;
                relu_q  <= cfg_relu;
            end
            s1_valid <= accept;
            if (accept)
                s1_sum <= sum_c;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= q_out;
                if ((sat_hi || sat_lo) && (sat_count != 16'hFFFF))
                    sat_count <= sat_count + 16'd1;
            end
            if (s2_valid)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(s2_valid) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (s2_valid)
            mem[wr_ptr] <= s2_data;
    end
endmodule

// File: tb/tb_acc_requantize.sv
// Directed bench for acc_requantize: rounding, saturation, ReLU,
// backpressure, config gating and mid-stream reset.
module tb_acc_requantize;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        cfg_load = 1'b0;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [15:0] sat_count;
    logic        busy;

    int checks = 0;
    int failures = 0;

    acc_requantize dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_load(cfg_load), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_count(sat_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int sh, input logic r);
        cfg_shift = 5'(sh);
        cfg_relu = r;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50)
            check("push_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] e);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_data), 32'(e));
        tick();
        out_ready = 1'b0;
    endtask

    // A write into a full FIFO must be impossible.
    always @(negedge clk)
        if (!reset)
            check("fifo_full_write",
                  32'(dut.s2_valid && (dut.count == 3'd4)), 32'd0);

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got_q[$];
        int sent;
        bit a;
        bit p;
        logic [15:0] d;

        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sat", 32'(sat_count), 32'd0);

        // Rounding with explicit latency check
        cfg(4, 1'b0);
        in_valid = 1'b1;
        in_data = 32'h0000_0018;
        tick();
        in_valid = 1'b0;
        check("lat_k1", 32'(out_valid), 32'd0);
        tick();
        check("lat_k2", 32'(out_valid), 32'd0);
        tick();
        check("lat_k3", 32'(out_valid), 32'd1);
        check("round_pos", 32'(out_data), 32'h0002);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        push(32'hFFFF_FFE8);
        pop_expect("round_neg", 16'hFFFF);
        check("round_sat", 32'(sat_count), 32'd0);

        // Saturation
        cfg(0, 1'b0);
        push(32'h0001_2345);
        pop_expect("sat_hi", 16'h7FFF);
        push(32'hFFFE_0000);
        pop_expect("sat_lo", 16'h8000);
        check("sat_count2", 32'(sat_count), 32'd2);

        // ReLU
        cfg(0, 1'b1);
        push(32'hFFFF_FFFB);
        pop_expect("relu_neg", 16'h0000);
        check("relu_sat", 32'(sat_count), 32'd2);
        push(32'h0000_0005);
        pop_expect("relu_pos", 16'h0005);

        // Backpressure
        cfg(0, 1'b0);
        out_ready = 1'b0;
        sent = 0;
        in_valid = 1'b1;
        in_data = 32'd1;
        for (int c = 0; c < 10; c++) begin
            a = in_ready;
            tick();
            if (a) begin
                sent++;
                in_data = 32'(sent + 1);
            end
        end
        check("bp_accepted", 32'(sent), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
            a = in_valid && in_ready;
            p = out_valid;
            d = out_data;
            tick();
            if (p)
                got_q.push_back(d);
            if (a) begin
                sent++;
                if (sent < 6)
                    in_data = 32'(sent + 1);
                else
                    in_valid = 1'b0;
            end
        end
        check("bp_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size(); i++)
            check("bp_order", 32'(got_q[i]), 32'(i + 1));
        tick();
        tick();
        tick();
        check("bp_no_extra", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Config gating
        push(32'h0000_0100);
        check("gate_busy", 32'(busy), 32'd1);
        cfg(8, 1'b0);
        pop_expect("gate_old_shift", 16'h0100);
        tick();
        check("gate_idle", 32'(busy), 32'd0);
        cfg(8, 1'b0);
        push(32'h0000_1280);
        pop_expect("gate_new_shift", 16'h0013);

        // Reset mid-stream
        push(32'h0000_0100);
        push(32'h0000_0200);
        push(32'h0000_0300);
        tick();
        tick();
        check("mid_buffered", 32'(dut.count), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_sat", 32'(sat_count), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        push(32'h0000_0007);
        pop_expect("mid_new", 16'h0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
